// File: rtl/prog_lut_pkg.sv
// prog_lut_pkg: shared types and constants for the programmable LUT.
// Holds the loader state enum, input-count limit and default table.
package prog_lut_pkg;

  localparam int N_IN_MAX = 6;

  localparam logic [15:0] DEFAULT_TABLE_4 = 16'hC1E1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD,
    ST_CHECK,
    ST_COMMIT
  } lut_state_e;

endpackage

// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: serial table loader (shadow reg, bit counter, FSM).
// In: clk, rst_n, cfg_start/valid/bit. Out: cfg_ready/done/err,
// commit (copy strobe), shadow (staged table). Macro: LUT_PARITY_EN.
module lut_cfg_loader
  import prog_lut_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic                 cfg_valid,
  input  logic                 cfg_bit,
  output logic                 cfg_ready,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic                 commit,
  output logic [2**N_IN-1:0]   shadow
);

  localparam int W  = 2**N_IN;
  localparam int CW = N_IN + 1;

  lut_state_e      state;
  lut_state_e      state_nx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nx;
  logic [W-1:0]    shadow_nx;
  logic            xfer;
  logic            last;

  assign cfg_ready = (state == ST_LOAD) || (state == ST_CHECK);
  assign xfer      = cfg_valid && cfg_ready;
  assign last      = (cnt == CW'(W - 1));
  assign commit    = (state == ST_COMMIT);
  assign cfg_done  = commit;

`ifdef LUT_PARITY_EN
  logic err_nx;
  logic err_q;
  assign cfg_err = err_q;
`else
  assign cfg_err = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    shadow_nx = shadow;
`ifdef LUT_PARITY_EN
    err_nx    = 1'b0;
`endif
    unique case (state)
      ST_RUN: begin
        if (cfg_start) begin
          state_nx  = ST_LOAD;
          cnt_nx    = '0;
          shadow_nx = '0;
        end
      end
      ST_LOAD: begin
        if (cfg_start) begin
          cnt_nx    = '0;
          shadow_nx = '0;
        end else if (xfer) begin
          // LSB-first: bit 0 ends at shadow[0] after W shifts
          shadow_nx = {cfg_bit, shadow[W-1:1]};
          cnt_nx    = cnt + 1'b1;
          if (last) begin
`ifdef LUT_PARITY_EN
            state_nx = ST_CHECK;
`else
            state_nx = ST_COMMIT;
`endif
          end
        end
      end
`ifdef LUT_PARITY_EN
      ST_CHECK: begin
        if (cfg_start) begin
          state_nx  = ST_LOAD;
          cnt_nx    = '0;
          shadow_nx = '0;
        end else if (xfer) begin
          // even parity over table plus parity bit
          if (^{shadow, cfg_bit}) begin
            err_nx   = 1'b1;
            state_nx = ST_RUN;
          end else begin
            state_nx = ST_COMMIT;
          end
        end
      end
`endif
      ST_COMMIT: begin
        if (cfg_start) begin
          state_nx  = ST_LOAD;
          cnt_nx    = '0;
          shadow_nx = '0;
        end else begin
          state_nx = ST_RUN;
        end
      end
      default: state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      cnt    <= '0;
      shadow <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      shadow <= shadow_nx;
    end
  end

`ifdef LUT_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_nx;
    end
  end
`endif

endmodule

// File: rtl/prog_lut_eval.sv
// prog_lut_eval: N_IN-input LUT with double-buffered serial reload.
// In: clk, rst_n, in_valid/in_vec, cfg_*. Out: out_valid/out_bit,
// cfg_ready/done/err. Optional parity check: LUT_PARITY_EN.
module prog_lut_eval
  import prog_lut_pkg::*;
#(
  parameter int                N_IN       = 4,
  parameter logic [2**N_IN-1:0] INIT_TABLE = DEFAULT_TABLE_4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  output logic            out_bit,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_ready,
  output logic            cfg_done,
  output logic            cfg_err
);

  logic [2**N_IN-1:0] active;
  logic [2**N_IN-1:0] shadow;
  logic               commit;

  lut_cfg_loader #(
    .N_IN (N_IN)
  ) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .commit    (commit),
    .shadow    (shadow)
  );

  // lookups in the commit cycle still see the old table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= INIT_TABLE;
    end else if (commit) begin
      active <= shadow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_bit <= active[in_vec];
      end
    end
  end

endmodule

// File: tb/tb_prog_lut_eval.sv
// tb_prog_lut_eval: directed self-checking bench for prog_lut_eval.
// Define LUT_PARITY_EN to also exercise the parity path.
module tb_prog_lut_eval;
  import prog_lut_pkg::*;

`ifdef LUT_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_vec;
  logic       out_valid;
  logic       out_bit;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_bit;
  logic       cfg_ready;
  logic       cfg_done;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  prog_lut_eval #(
    .N_IN       (4),
    .INIT_TABLE (16'hC1E1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic eval(input logic [3:0] v, input logic e);
    in_valid = 1'b1;
    in_vec   = v;
    tick();
    chk("eval_valid", out_valid, 1);
    chk($sformatf("eval_bit[%0h]", v), out_bit, e);
  endtask

  // full load with continuous in_vec sweep; optional aborted prefix
  task automatic run_load(input logic [15:0] old_t,
                          input logic [15:0] new_t,
                          input int pre, input logic par_bit,
                          input bit exp_err);
    int s;
    int l;
    int p;
    int c;
    bit ok;
    logic [15:0] t;
    s  = (pre > 0) ? pre + 1 : 0;
    l  = s + 16;
    p  = PAR ? l + 1 : l;
    c  = p + 1;
    ok = !(PAR && exp_err);
    for (int cyc = 0; cyc <= c + 17; cyc++) begin
      cfg_start = (cyc == 0) || (pre > 0 && cyc == pre + 1);
      cfg_valid = 1'b0;
      cfg_bit   = 1'b0;
      if (pre > 0 && cyc >= 1 && cyc <= pre) begin
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
      end
      if (cyc > s && cyc <= l) begin
        cfg_valid = 1'b1;
        cfg_bit   = new_t[cyc-s-1];
      end
      if (PAR && cyc == p) begin
        cfg_valid = 1'b1;
        cfg_bit   = par_bit;
      end
      in_valid = 1'b1;
      in_vec   = 4'(cyc % 16);
      tick();
      t = (ok && cyc > c) ? new_t : old_t;
      chk("load_eval_valid", out_valid, 1);
      chk($sformatf("load_eval_bit@%0d", cyc), out_bit, t[cyc%16]);
      chk($sformatf("cfg_ready@%0d", cyc), cfg_ready, (cyc + 1 <= p));
      chk($sformatf("cfg_done@%0d", cyc), cfg_done, ok && cyc == p);
      chk($sformatf("cfg_err@%0d", cyc), cfg_err,
          PAR && exp_err && cyc == p);
    end
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst_n = 1'b1;
    tick();

    eval(4'h5, 1'b1);
    eval(4'h2, 1'b0);
    eval(4'hF, 1'b1);
    eval(4'h8, 1'b1);
    in_valid = 1'b0;
    tick();
    chk("idle_out_valid", out_valid, 0);
    chk("idle_out_bit_hold", out_bit, 1);

    // cfg_valid in RUN must be ignored
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run_ready", cfg_ready, 0);
      chk("run_done", cfg_done, 0);
    end
    cfg_valid = 1'b0;
    eval(4'h0, 1'b1);
    eval(4'h1, 1'b0);

    run_load(16'hC1E1, 16'h8000, 0, 1'b1, 1'b0);
    eval(4'hF, 1'b1);
    eval(4'hE, 1'b0);
    eval(4'h0, 1'b0);

    run_load(16'h8000, 16'h0001, 7, 1'b1, 1'b0);
    eval(4'h0, 1'b1);
    eval(4'hF, 1'b0);

    // reset in the middle of a load
    in_valid  = 1'b1;
    in_vec    = 4'h0;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_load_ready", cfg_ready, 1);
    chk("mid_load_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_cfg_ready", cfg_ready, 0);
    chk("arst_state", dut.u_loader.state, ST_RUN);
    tick();
    chk("arst_out_bit", out_bit, 0);
    rst_n     = 1'b1;
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    tick();
    chk("post_rst_ready", cfg_ready, 0);
    eval(4'h5, 1'b1);
    eval(4'h2, 1'b0);
    eval(4'hF, 1'b1);
    eval(4'h8, 1'b1);
    eval(4'h0, 1'b1);
    in_valid = 1'b0;

`ifdef LUT_PARITY_EN
    run_load(16'hC1E1, 16'hC1E1, 0, 1'b1, 1'b0);
    run_load(16'hC1E1, 16'h0001, 0, 1'b0, 1'b1);
    eval(4'h5, 1'b1);
    eval(4'h0, 1'b1);
    eval(4'h2, 1'b0);
    in_valid = 1'b0;
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
